// File: rtl/sfx_mixer.sv
//------------------------------------------------------------------------------
// Module   : sfx_mixer
// Purpose  : Two-voice sound-effect mixer feeding the I2S serializer. On each
//            sample_req it fetches one byte per voice from a shared sample ROM
//            (one voice slot after the other), converts offset-binary to
//            signed, sums, saturates to 8 bits and presents the result with a
//            one-cycle sample_valid strobe. Voices are started and stopped
//            through a single Avalon-MM control/status register.
// Ports    : CLK, RESET_N (async, active low)
//            AVL_READ/WRITE/CS/ADDR/WRITEDATA/READDATA - control register
//            sample_req    - per-frame request from serializer
//            rom_sel/addr  - shared ROM request (data returns 1 CLK later)
//            rom_data      - unsigned ROM byte, midpoint 128
//            sample_out    - mixed signed sample, held between frames
//            sample_valid  - one-CLK pulse when sample_out updates
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sfx_mixer #(
    parameter int ADDR_W = 15,
    parameter int LEN0   = 22050,
    parameter int LEN1   = 4410
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              AVL_READ,
    input  logic              AVL_WRITE,
    input  logic              AVL_CS,
    input  logic [1:0]        AVL_ADDR,
    input  logic [31:0]       AVL_WRITEDATA,
    output logic [31:0]       AVL_READDATA,
    input  logic              sample_req,
    output logic              rom_sel,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [7:0]        sample_out,
    output logic              sample_valid
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE0 = 3'd1;
    localparam logic [2:0] S_CAP0   = 3'd2;
    localparam logic [2:0] S_ISSUE1 = 3'd3;
    localparam logic [2:0] S_CAP1   = 3'd4;
    localparam logic [2:0] S_OUT    = 3'd5;

    localparam logic [ADDR_W-1:0] c_LAST0 = ADDR_W'(LEN0 - 1);
    localparam logic [ADDR_W-1:0] c_LAST1 = ADDR_W'(LEN1 - 1);

    logic [2:0]        state_q, state_d;
    logic [1:0]        active_q, active_d;
    logic [ADDR_W-1:0] ptr0_q, ptr0_d;
    logic [ADDR_W-1:0] ptr1_q, ptr1_d;
    logic [1:0]        pend_trig_q, pend_trig_d;
    logic [1:0]        pend_stop_q, pend_stop_d;
    logic              overrun_q, overrun_d;
    logic signed [9:0] acc_q, acc_d;
    logic [7:0]        sample_q, sample_d;
    logic              valid_q, valid_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              w_wr;
    logic [1:0]        w_trig;
    logic [1:0]        w_stop;
    logic [1:0]        w_app_trig;
    logic [1:0]        w_app_stop;
    logic signed [9:0] w_voice;
    logic signed [9:0] w_sum;
    logic              w_unused;

    assign w_wr   = AVL_CS && AVL_WRITE && (AVL_ADDR == 2'd0);
    assign w_trig = w_wr ? AVL_WRITEDATA[1:0]   : 2'b00;
    assign w_stop = w_wr ? AVL_WRITEDATA[17:16] : 2'b00;

    // Offset-binary ROM byte to signed value in [-128,127].
    assign w_voice = $signed({2'b00, rom_data}) - 10'sd128;
    assign w_sum   = acc_q + (active_q[1] ? w_voice : 10'sd0);

    assign w_unused = &{1'b0, AVL_WRITEDATA[31:18], AVL_WRITEDATA[15:9],
                        AVL_WRITEDATA[7:2]};

    // ROM request is decoded straight from the state so the address is on
    // the bus during ISSUEx and the registered ROM answers during CAPx.
    always_comb begin
        rom_sel  = 1'b0;
        rom_addr = '0;
        if (state_q == S_ISSUE0) begin
            rom_addr = ptr0_q;
        end else if (state_q == S_ISSUE1) begin
            rom_sel  = 1'b1;
            rom_addr = ptr1_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        active_d    = active_q;
        ptr0_d      = ptr0_q;
        ptr1_d      = ptr1_q;
        pend_trig_d = pend_trig_q;
        pend_stop_d = pend_stop_q;
        overrun_d   = overrun_q;
        acc_d       = acc_q;
        sample_d    = sample_q;
        valid_d     = 1'b0;
        w_app_trig  = 2'b00;
        w_app_stop  = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (sample_req) state_d = S_ISSUE0;
                w_app_trig = w_trig;
                w_app_stop = w_stop;
            end
            S_ISSUE0: state_d = S_ISSUE1 - 3'd1;
            S_CAP0: begin
                acc_d   = active_q[0] ? w_voice : 10'sd0;
                state_d = S_ISSUE1;
            end
            S_ISSUE1: state_d = S_CAP1;
            S_CAP1: begin
                if (w_sum > 10'sd127)       sample_d = 8'h7F;
                else if (w_sum < -10'sd128) sample_d = 8'h80;
                else                        sample_d = w_sum[7:0];
                valid_d = 1'b1;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (active_q[0]) begin
                    if (ptr0_q == c_LAST0) begin
                        active_d[0] = 1'b0;
                        ptr0_d      = '0;
                    end else begin
                        ptr0_d = ptr0_q + 1'b1;
                    end
                end
                if (active_q[1]) begin
                    if (ptr1_q == c_LAST1) begin
                        active_d[1] = 1'b0;
                        ptr1_d      = '0;
                    end else begin
                        ptr1_d = ptr1_q + 1'b1;
                    end
                end
                // A write landing in this very cycle is folded in as well.
                w_app_trig  = pend_trig_q | w_trig;
                w_app_stop  = pend_stop_q | w_stop;
                pend_trig_d = 2'b00;
                pend_stop_d = 2'b00;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE && state_q != S_OUT) begin
            pend_trig_d = pend_trig_q | w_trig;
            pend_stop_d = pend_stop_q | w_stop;
        end

        // Trigger/stop application runs after the pointer advance; stop wins.
        if (w_app_stop[0]) begin
            active_d[0] = 1'b0;
            ptr0_d      = '0;
        end else if (w_app_trig[0]) begin
            active_d[0] = 1'b1;
            ptr0_d      = '0;
        end
        if (w_app_stop[1]) begin
            active_d[1] = 1'b0;
            ptr1_d      = '0;
        end else if (w_app_trig[1]) begin
            active_d[1] = 1'b1;
            ptr1_d      = '0;
        end

        // A new overrun in the same cycle as a clear keeps the flag set.
        if (w_wr && AVL_WRITEDATA[8]) overrun_d = 1'b0;
        if (sample_req && state_q != S_IDLE) overrun_d = 1'b1;

        rdata_d = rdata_q;
        if (AVL_READ && AVL_CS) begin
            rdata_d = (AVL_ADDR == 2'd0) ?
                      {23'b0, overrun_q, 6'b0, active_q} : 32'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= S_IDLE;
            active_q    <= 2'b00;
            ptr0_q      <= '0;
            ptr1_q      <= '0;
            pend_trig_q <= 2'b00;
            pend_stop_q <= 2'b00;
            overrun_q   <= 1'b0;
            acc_q       <= '0;
            sample_q    <= 8'h00;
            valid_q     <= 1'b0;
            rdata_q     <= 32'b0;
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            ptr0_q      <= ptr0_d;
            ptr1_q      <= ptr1_d;
            pend_trig_q <= pend_trig_d;
            pend_stop_q <= pend_stop_d;
            overrun_q   <= overrun_d;
            acc_q       <= acc_d;
            sample_q    <= sample_d;
            valid_q     <= valid_d;
            rdata_q     <= rdata_d;
        end
    end

    assign AVL_READDATA = rdata_q;
    assign sample_out   = sample_q;
    assign sample_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_sfx_mixer.sv
//------------------------------------------------------------------------------
// Module   : tb_sfx_mixer
// Purpose  : Directed self-checking bench for sfx_mixer with a registered
//            ROM model whose contents are selected by rom_mode.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sfx_mixer;

    localparam int ADDR_W = 15;
    localparam int LEN0   = 22050;
    localparam int LEN1   = 4410;

    logic              CLK = 1'b0;
    logic              RESET_N = 1'b0;
    logic              AVL_READ = 1'b0;
    logic              AVL_WRITE = 1'b0;
    logic              AVL_CS = 1'b0;
    logic [1:0]        AVL_ADDR = 2'd0;
    logic [31:0]       AVL_WRITEDATA = 32'd0;
    logic [31:0]       AVL_READDATA;
    logic              sample_req = 1'b0;
    logic              rom_sel;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data = 8'd0;
    logic [7:0]        sample_out;
    logic              sample_valid;

    int n_tests = 0;
    int n_fail  = 0;
    int rom_mode = 0;

    sfx_mixer #(.ADDR_W(ADDR_W), .LEN0(LEN0), .LEN1(LEN1)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE), .AVL_CS(AVL_CS),
        .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA),
        .AVL_READDATA(AVL_READDATA),
        .sample_req(sample_req), .rom_sel(rom_sel), .rom_addr(rom_addr),
        .rom_data(rom_data), .sample_out(sample_out),
        .sample_valid(sample_valid)
    );

    always #5 CLK = ~CLK;

    // Mode 0: address pattern; mode 1: 255/250; mode 2: all zero.
    function automatic logic [7:0] rom_fn(input logic sel, input logic [ADDR_W-1:0] a);
        int ai;
        ai = int'(a);
        if (rom_mode == 1) return sel ? 8'd250 : 8'd255;
        if (rom_mode == 2) return 8'd0;
        if (!sel) return (ai == 0) ? 8'd200 : 8'((ai * 3 + 17) & 255);
        return (ai == LEN1 - 1) ? 8'd10 : 8'((ai * 5 + 90) & 255);
    endfunction

    always @(posedge CLK) rom_data <= rom_fn(rom_sel, rom_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic avl_write(input logic [31:0] d);
        AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = 2'd0; AVL_WRITEDATA = d;
        tick();
        AVL_CS = 1'b0; AVL_WRITE = 1'b0; AVL_WRITEDATA = 32'd0;
    endtask

    task automatic avl_read(output logic [31:0] d);
        AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = 2'd0;
        tick();
        AVL_CS = 1'b0; AVL_READ = 1'b0;
        d = AVL_READDATA;
    endtask

    // One full frame; returns sample, latency in cycles and the ROM
    // addresses seen in the ISSUE0 and ISSUE1 slots.
    task automatic frame(output logic [7:0] smp, output int lat,
                         output logic [ADDR_W-1:0] a0, output logic [ADDR_W-1:0] a1);
        a1 = '0;
        sample_req = 1'b1;
        tick();
        sample_req = 1'b0;
        lat = 1;
        a0 = rom_addr;
        while (!sample_valid && lat < 10) begin
            tick();
            lat++;
            if (lat == 3) a1 = rom_addr;
        end
        smp = sample_out;
        tick();
    endtask

    initial begin
        logic [7:0]        smp;
        int                lat;
        int                nv;
        logic [ADDR_W-1:0] a0, a1;
        logic [31:0]       rd;

        #1;
        check("rst_sample_out", 32'(sample_out), 32'h0);
        check("rst_sample_valid", 32'(sample_valid), 32'h0);
        check("rst_rom_sel", 32'(rom_sel), 32'h0);
        check("rst_rom_addr", 32'(rom_addr), 32'h0);
        check("rst_readdata", AVL_READDATA, 32'h0);
        #20;
        RESET_N = 1'b1;
        tick();

        // Idle frame
        frame(smp, lat, a0, a1);
        check("idle_latency", 32'(lat), 32'd5);
        check("idle_sample", 32'(smp), 32'h00);
        check("valid_one_cycle", 32'(sample_valid), 32'h0);
        avl_read(rd);
        check("status_idle", rd, 32'h0);

        // Voice 0 alone
        avl_write(32'h1);
        avl_read(rd);
        check("status_v0", rd, 32'h1);
        frame(smp, lat, a0, a1);
        check("v0_f0_addr", 32'(a0), 32'd0);
        check("v0_f0_sample", 32'(smp), 32'h48);
        frame(smp, lat, a0, a1);
        check("v0_f1_addr", 32'(a0), 32'd1);
        check("v0_f1_sample", 32'(smp), 32'h94);

        // Both voices, saturation limits
        avl_write(32'h2);
        rom_mode = 1;
        frame(smp, lat, a0, a1);
        check("sat_pos", 32'(smp), 32'h7F);
        rom_mode = 2;
        frame(smp, lat, a0, a1);
        check("sat_neg", 32'(smp), 32'h80);
        check("sat_neg_latency", 32'(lat), 32'd5);

        // Run voice 1 up to its last sample (ptr1 2 -> LEN1-1)
        rom_mode = 0;
        for (int i = 0; i < LEN1 - 3; i++) frame(smp, lat, a0, a1);
        frame(smp, lat, a0, a1);
        check("v1_last_addr", 32'(a1), 32'(LEN1 - 1));
        check("v1_last_sample", 32'(smp), 32'hCC);
        avl_read(rd);
        check("status_v1_done", rd, 32'h1);
        frame(smp, lat, a0, a1);
        check("v1_ptr_wrapped", 32'(a1), 32'd0);
        check("v1_done_sample", 32'(smp), 32'h45);

        // Overrun: second request two cycles after the first
        sample_req = 1'b1;
        tick();
        sample_req = 1'b0;
        tick();
        sample_req = 1'b1;
        tick();
        sample_req = 1'b0;
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            if (sample_valid) nv++;
            tick();
        end
        check("overrun_one_valid", 32'(nv), 32'd1);
        avl_read(rd);
        check("status_overrun", rd, 32'h101);
        avl_write(32'h100);
        avl_read(rd);
        check("status_ovr_clr", rd, 32'h1);

        // Retrigger voice 0 during CAP1
        sample_req = 1'b1;
        tick();
        sample_req = 1'b0;
        a0 = rom_addr;
        tick();
        tick();
        tick();
        avl_write(32'h1);
        check("retrig_old_addr", 32'(a0), 32'd4414);
        check("retrig_valid", 32'(sample_valid), 32'h1);
        check("retrig_sample", 32'(sample_out), 32'h4B);
        tick();
        frame(smp, lat, a0, a1);
        check("retrig_new_addr", 32'(a0), 32'd0);
        check("retrig_new_sample", 32'(smp), 32'h48);

        // Stop wins over trigger in one write
        avl_write(32'h10001);
        avl_read(rd);
        check("stop_wins", rd, 32'h0);

        // Reset in the middle of a frame
        avl_write(32'h1);
        sample_req = 1'b1;
        tick();
        sample_req = 1'b0;
        tick();
        RESET_N = 1'b0;
        #1;
        check("midrst_sample_out", 32'(sample_out), 32'h0);
        check("midrst_valid", 32'(sample_valid), 32'h0);
        #12;
        RESET_N = 1'b1;
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (sample_valid) nv++;
        end
        check("midrst_no_valid", 32'(nv), 32'd0);
        avl_read(rd);
        check("midrst_status", rd, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
